// File: rtl/lcd_interface_pkg.sv
// lcd_interface_pkg
//   Shared definitions for the HD44780 4-bit write-only driver:
//   - controller command bytes
//   - strobe phase lengths in cycles
//   - FSM and strobe-phase enums
//   - helpers that turn microsecond delays into cycle counts for a given CLK_MHZ
package lcd_interface_pkg;

  // Wide enough for the 15 ms power-on wait at several hundred MHz.
  localparam int DLY_W = 24;

  localparam logic [7:0] FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] ENTRY    = 8'h06;  // increment cursor, no shift
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] DDRAM_L1 = 8'h80;  // DDRAM address 0x00, line 1 column 0

  // Last count value of each strobe phase (setup 2, E high 12, hold 1 cycles).
  localparam logic [DLY_W-1:0] SETUP_LAST  = DLY_W'(2 - 1);
  localparam logic [DLY_W-1:0] STROBE_LAST = DLY_W'(12 - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST   = DLY_W'(1 - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, IDLE, ADDR, CHAR} lcd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD, W_DELAY} wr_phase_t;

  function automatic logic [DLY_W-1:0] us_to_cyc(input int unsigned us,
                                                 input int unsigned clk_mhz);
    int unsigned cyc;
    cyc = us * clk_mhz;
    return cyc[DLY_W-1:0];
  endfunction

  function automatic logic [DLY_W-1:0] pwr_wait_cyc(input int unsigned clk_mhz);
    return us_to_cyc(15000, clk_mhz);
  endfunction

  // Waits after the four bare init nibbles: 4.1 ms, 100 us, 40 us, 40 us.
  function automatic logic [DLY_W-1:0] init_wait_cyc(input logic [1:0] step,
                                                     input int unsigned clk_mhz);
    case (step)
      2'd0:    return us_to_cyc(4100, clk_mhz);
      2'd1:    return us_to_cyc(100, clk_mhz);
      default: return us_to_cyc(40, clk_mhz);
    endcase
  endfunction

  function automatic logic [DLY_W-1:0] nibble_gap_cyc(input int unsigned clk_mhz);
    return us_to_cyc(1, clk_mhz);
  endfunction

  function automatic logic [DLY_W-1:0] cmd_wait_cyc(input int unsigned clk_mhz);
    return us_to_cyc(40, clk_mhz);
  endfunction

  function automatic logic [DLY_W-1:0] clear_wait_cyc(input int unsigned clk_mhz);
    return us_to_cyc(1640, clk_mhz);
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] step);
    case (step)
      2'd0:    return FUNC_SET;
      2'd1:    return ENTRY;
      2'd2:    return DISP_ON;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer
//   Writes one nibble to the LCD bus and then waits a programmable delay:
//   setup (2 cycles, E=0), E high (12 cycles), hold (1 cycle, E=0),
//   then delay_cycles of idle bus.
//   Ports:
//     Clk, Rst      clock, asynchronous active-high reset
//     start         accepted only while not busy
//     nibble, rs    value and register select captured on start
//     delay_cycles  post-write wait, captured on start
//     busy          high from the cycle after start until the delay expires
//     lcd_data, lcd_e, lcd_rs  bus pins; data/rs hold their last value
module lcd_nibble_writer
  import lcd_interface_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [3:0]       nibble,
  input  logic             rs,
  input  logic [DLY_W-1:0] delay_cycles,
  output logic             busy,
  output logic [3:0]       lcd_data,
  output logic             lcd_e,
  output logic             lcd_rs
);

  wr_phase_t        phase, phase_d;
  logic [DLY_W-1:0] cnt, cnt_d, dly;
  logic             accept;

  assign accept = start && (phase == W_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      phase    <= W_IDLE;
      cnt      <= '0;
      dly      <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
    end else begin
      phase <= phase_d;
      cnt   <= cnt_d;
      if (accept) begin
        lcd_data <= nibble;
        lcd_rs   <= rs;
        dly      <= delay_cycles;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    phase_d = phase;
    cnt_d   = cnt + DLY_W'(1);
    case (phase)
      W_IDLE: begin
        cnt_d = '0;
        if (start) phase_d = W_SETUP;
      end
      W_SETUP: if (cnt == SETUP_LAST) begin
        phase_d = W_STROBE;
        cnt_d   = '0;
      end
      W_STROBE: if (cnt == STROBE_LAST) begin
        phase_d = W_HOLD;
        cnt_d   = '0;
      end
      W_HOLD: if (cnt == HOLD_LAST) begin
        phase_d = (dly == '0) ? W_IDLE : W_DELAY;
        cnt_d   = '0;
      end
      W_DELAY: if (cnt == dly - DLY_W'(1)) begin
        phase_d = W_IDLE;
        cnt_d   = '0;
      end
      default: begin
        phase_d = W_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (phase != W_IDLE);
  // Decoded straight from the phase flop so an asynchronous reset drops E at once.
  assign lcd_e = (phase == W_STROBE);

endmodule

// File: rtl/lcd_interface.sv
// lcd_interface
//   Runs HD44780 power-on initialisation over a 4-bit bus, then rewrites
//   line 1 with the 16-character Display string each time GO is accepted.
//   Ports:
//     Clk, Rst   clock, asynchronous active-high reset
//     GO         single-cycle update request (coalesced via a pending flag)
//     Display    16 ASCII bytes, [128:121] is column 0
//     LCD_Data   data nibble, LCD_E enable, LCD_RS register select
//     LCD_RW     tied 0 (write only)
module lcd_interface
  import lcd_interface_pkg::*;
#(
  parameter int unsigned CLK_MHZ = 50
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         GO,
  input  logic [128:1] Display,
  output logic [11:8]  LCD_Data,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW
);

  lcd_state_t       state, state_d, next_state;
  logic [3:0]       idx, idx_d;      // step / byte index within the state
  logic             half, half_d;    // 0 = high nibble of a byte, 1 = low
  logic [DLY_W-1:0] pwr_cnt;
  logic             pending, accept;
  logic [127:0]     line_buf;

  logic             want, byte_mode, last, slow;
  logic [7:0]       cur_byte;
  logic             wr_start, wr_rs, wr_busy;
  logic [3:0]       wr_nibble;
  logic [DLY_W-1:0] wr_delay;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= PWR_WAIT;
      idx     <= '0;
      half    <= 1'b0;
      pwr_cnt <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      half    <= half_d;
      pwr_cnt <= (state == PWR_WAIT) ? pwr_cnt + DLY_W'(1) : '0;
      pending <= GO | (pending & ~accept);
    end
  end

  // NOTE: the line buffer is pure data, only read after a load, so it carries
  // no reset.
  always_ff @(posedge Clk) begin
    if (accept) line_buf <= Display;
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    half_d     = half;
    next_state = state;
    accept     = 1'b0;
    want       = 1'b0;
    byte_mode  = 1'b0;
    last       = 1'b0;
    slow       = 1'b0;
    cur_byte   = 8'h00;
    wr_rs      = 1'b0;
    wr_nibble  = 4'h0;
    wr_delay   = '0;

    case (state)
      // The first init nibble is launched on the last wait cycle so that
      // its E rises exactly 15 ms + 2 setup cycles after reset.
      PWR_WAIT: begin
        want       = (pwr_cnt == pwr_wait_cyc(CLK_MHZ) - DLY_W'(1));
        wr_nibble  = 4'h3;
        wr_delay   = init_wait_cyc(2'd0, CLK_MHZ);
        last       = 1'b1;
        next_state = INIT;
      end
      // Remaining bare nibbles 0x3, 0x3, 0x2 (init steps 1..3).
      INIT: begin
        want       = 1'b1;
        wr_nibble  = (idx == 4'd2) ? 4'h2 : 4'h3;
        wr_delay   = init_wait_cyc(idx[1:0] + 2'd1, CLK_MHZ);
        last       = (idx == 4'd2);
        next_state = CFG;
      end
      CFG: begin
        want       = 1'b1;
        byte_mode  = 1'b1;
        cur_byte   = cfg_byte(idx[1:0]);
        last       = (idx == 4'd3);
        slow       = (idx == 4'd3);   // Clear needs the long wait
        next_state = IDLE;
      end
      IDLE: begin
        if (pending) begin
          accept  = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        want       = 1'b1;
        byte_mode  = 1'b1;
        cur_byte   = DDRAM_L1;
        last       = 1'b1;
        next_state = CHAR;
      end
      CHAR: begin
        want       = 1'b1;
        byte_mode  = 1'b1;
        wr_rs      = 1'b1;
        cur_byte   = line_buf[{~idx, 3'b000} +: 8];  // column idx, column 0 at MSB
        last       = (idx == 4'd15);
        next_state = IDLE;
      end
      default: state_d = PWR_WAIT;
    endcase

    if (byte_mode) begin
      wr_nibble = half ? cur_byte[3:0] : cur_byte[7:4];
      if (!half)     wr_delay = nibble_gap_cyc(CLK_MHZ);
      else if (slow) wr_delay = clear_wait_cyc(CLK_MHZ);
      else           wr_delay = cmd_wait_cyc(CLK_MHZ);
    end

    // A new state may be entered while the writer still runs its delay;
    // its first write simply waits for busy to clear.
    wr_start = want && !wr_busy;
    if (wr_start) begin
      if (byte_mode && !half) begin
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        if (last) begin
          state_d = next_state;
          idx_d   = '0;
        end else begin
          idx_d = idx + 4'd1;
        end
      end
    end
  end

  lcd_nibble_writer u_writer (
    .Clk          (Clk),
    .Rst          (Rst),
    .start        (wr_start),
    .nibble       (wr_nibble),
    .rs           (wr_rs),
    .delay_cycles (wr_delay),
    .busy         (wr_busy),
    .lcd_data     (LCD_Data),
    .lcd_e        (LCD_E),
    .lcd_rs       (LCD_RS)
  );

  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_interface.sv
// tb_lcd_interface
//   Directed bench for lcd_interface at CLK_MHZ = 1 (1 us = 1 cycle).
//   A negedge monitor records every E strobe (nibble, RS, rise and fall cycle);
//   scenario tasks compare those records against hand-derived values.
module tb_lcd_interface;

  localparam int unsigned MHZ = 1;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         GO  = 1'b0;
  logic [128:1] Display = '0;
  logic [11:8]  LCD_Data;
  logic         LCD_E, LCD_RS, LCD_RW;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] nib_q[$];
  logic       rs_q[$];
  int         rise_q[$];
  int         fall_q[$];
  logic       e_prev = 1'b0;

  logic [127:0] str_a = "v0=123 v1=045   ";
  logic [127:0] str_b = "ABCDEFGHIJKLMNOP";

  lcd_interface #(.CLK_MHZ(MHZ)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .GO       (GO),
    .Display  (Display),
    .LCD_Data (LCD_Data),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW)
  );

  initial forever #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (LCD_E && !e_prev) begin
      nib_q.push_back(LCD_Data);
      rs_q.push_back(LCD_RS);
      rise_q.push_back(cyc);
    end
    if (!LCD_E && e_prev) fall_q.push_back(cyc);
    e_prev = LCD_E;
  end

  function automatic logic [7:0] col_byte(input logic [127:0] s, input int c);
    return s[8*(15-c) +: 8];
  endfunction

  task automatic clear_caps();
    nib_q.delete();
    rs_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k = 0;
    while (fall_q.size() < n && k < budget) begin
      @(negedge Clk);
      k++;
    end
    n_cmp++;
    if (fall_q.size() < n) begin
      n_bad++;
      $display("FAIL %s: strobes seen %0d, required %0d", name, fall_q.size(), n);
    end
  endtask

  task automatic pulse_go();
    @(negedge Clk) GO = 1'b1;
    @(negedge Clk) GO = 1'b0;
  endtask

  // Checks one update (ADDR byte + 16 characters) starting at queue index base.
  task automatic check_update(input int base, input logic [127:0] s, input string name);
    n_cmp++;
    if ({nib_q[base], nib_q[base+1], rs_q[base], rs_q[base+1]} !== {4'h8, 4'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL %s addr: got %h%h rs %b%b, required 80 rs 00", name,
               nib_q[base], nib_q[base+1], rs_q[base], rs_q[base+1]);
    end
    for (int c = 0; c < 16; c++) begin
      n_cmp++;
      if ({nib_q[base+2+2*c], nib_q[base+3+2*c], rs_q[base+2+2*c], rs_q[base+3+2*c]}
          !== {col_byte(s, c), 2'b11}) begin
        n_bad++;
        $display("FAIL %s col%0d: got %h%h rs %b%b, required %h rs 11", name, c,
                 nib_q[base+2+2*c], nib_q[base+3+2*c], rs_q[base+2+2*c], rs_q[base+3+2*c],
                 col_byte(s, c));
      end
    end
  endtask

  task automatic test_reset(output int rel);
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({LCD_Data, LCD_E, LCD_RS, LCD_RW} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required 0000000", {LCD_Data, LCD_E, LCD_RS, LCD_RW});
    end
    clear_caps();
    Rst = 1'b0;
    rel = cyc;
    wait_strobes(1, 16000, "reset_first_strobe");
    n_cmp++;
    if (rise_q.size() < 1 || rise_q[0] - rel !== 15002) begin
      n_bad++;
      $display("FAIL first_e_rise: got cycle %0d, required 15002",
               rise_q.size() > 0 ? rise_q[0] - rel : -1);
    end
    n_cmp++;
    if ({nib_q[0], rs_q[0]} !== {4'h3, 1'b0}) begin
      n_bad++;
      $display("FAIL first_nibble: got %h rs %b, required 3 rs 0", nib_q[0], rs_q[0]);
    end
  endtask

  task automatic test_init();
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    wait_strobes(12, 25000, "init_strobes");
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({nib_q[i], rs_q[i]} !== {exp_nib[i], 1'b0}) begin
        n_bad++;
        $display("FAIL init_nib%0d: got %h rs %b, required %h rs 0", i, nib_q[i], rs_q[i], exp_nib[i]);
      end
      n_cmp++;
      if (fall_q[i] - rise_q[i] !== 12) begin
        n_bad++;
        $display("FAIL init_width%0d: got %0d, required 12", i, fall_q[i] - rise_q[i]);
      end
    end
    n_cmp++;
    if (rise_q[1] - fall_q[0] < 4100) begin
      n_bad++;
      $display("FAIL init_4ms_wait: got %0d, required >= 4100", rise_q[1] - fall_q[0]);
    end
    repeat (2000) @(negedge Clk);
    n_cmp++;
    if (nib_q.size() !== 12) begin
      n_bad++;
      $display("FAIL init_no_extra: got %0d strobes, required 12", nib_q.size());
    end
  endtask

  task automatic test_update();
    int t0;
    Display = str_a;
    clear_caps();
    @(negedge Clk) GO = 1'b1;
    t0 = cyc;
    @(negedge Clk) GO = 0;
    wait_strobes(34, 3000, "update_strobes");
    n_cmp++;
    if (rise_q[0] - (t0 + 1) !== 4) begin
      n_bad++;
      $display("FAIL go_latency: got %0d, required 4", rise_q[0] - (t0 + 1));
    end
    check_update(0, str_a, "update");
    for (int k = 0; k < 34; k++) begin
      n_cmp++;
      if (fall_q[k] - rise_q[k] !== 12) begin
        n_bad++;
        $display("FAIL update_width%0d: got %0d, required 12", k, fall_q[k] - rise_q[k]);
      end
    end
    for (int k = 0; k < 33; k++) begin
      n_cmp++;
      if (rise_q[k+1] - fall_q[k] < ((k % 2 == 0) ? 1 : 40)) begin
        n_bad++;
        $display("FAIL update_gap%0d: got %0d, required >= %0d", k,
                 rise_q[k+1] - fall_q[k], (k % 2 == 0) ? 1 : 40);
      end
    end
  endtask

  task automatic test_rst_mid_strobe();
    int k = 0;
    int rel;
    clear_caps();
    pulse_go();
    while (!(LCD_E === 1'b1 && LCD_RS === 1'b1) && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    n_cmp++;
    if (k >= 3000) begin
      n_bad++;
      $display("FAIL rst_wait_char: got no character strobe, required one");
    end
    #2 Rst = 1'b1;
    #1;
    n_cmp++;
    if (LCD_E !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_e_drop: got E=%b, required 0", LCD_E);
    end
    n_cmp++;
    if ({LCD_Data, LCD_RS} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_pins: got %b, required 00000", {LCD_Data, LCD_RS});
    end
    repeat (2) @(negedge Clk);
    clear_caps();
    Rst = 1'b0;
    rel = cyc;
    wait_strobes(1, 16000, "rst_first_strobe");
    n_cmp++;
    if ({nib_q[0], rs_q[0]} !== {4'h3, 1'b0} || rise_q[0] - rel !== 15002) begin
      n_bad++;
      $display("FAIL rst_restart: got %h rs %b at %0d, required 3 rs 0 at 15002",
               nib_q[0], rs_q[0], rise_q[0] - rel);
    end
  endtask

  // Continues from the re-init started by test_rst_mid_strobe.
  task automatic test_coalesce();
    Display = str_a;
    pulse_go();
    wait_strobes(20, 30000, "coalesce_first_update");
    pulse_go();
    pulse_go();
    Display = str_b;
    wait_strobes(80, 5000, "coalesce_second_update");
    repeat (3000) @(negedge Clk);
    n_cmp++;
    if (nib_q.size() !== 80) begin
      n_bad++;
      $display("FAIL coalesce_count: got %0d strobes, required 80", nib_q.size());
    end
    check_update(12, str_a, "coalesce_upd1");
    check_update(46, str_b, "coalesce_upd2");
  endtask

  initial begin
    int rel;
    test_reset(rel);
    test_init();
    test_update();
    test_rst_mid_strobe();
    test_coalesce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
